// File: rtl/add_round_key_collect.sv
// Word-serial AddRoundKey: XORs each mixed column with its round-key word and
// assembles NUM_COLS columns into a registered state. Define ARK_PARITY_EN to add out_parity.
module add_round_key_collect #(
  parameter int NUM_COLS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_word,
  input  logic [32*NUM_COLS-1:0]  round_key,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [32*NUM_COLS-1:0]  out_state,
`ifdef ARK_PARITY_EN
  output logic [4*NUM_COLS-1:0]   out_parity,
`endif
  output logic                    busy
);

  localparam int CW = $clog2(NUM_COLS);
  localparam logic [CW-1:0] LAST_COL = CW'(NUM_COLS - 1);

  logic [CW-1:0]            col_cnt_q, col_cnt_d;
  logic [32*NUM_COLS-1:0]   acc_q, acc_d;
  logic [32*NUM_COLS-1:0]   key_q, key_d;
  logic [32*NUM_COLS-1:0]   out_state_q, out_state_d;
  logic                     out_valid_q, out_valid_d;

  logic [31:0]              key_word [NUM_COLS];
  logic [31:0]              kw;
  logic [31:0]              keyed;
  logic [32*NUM_COLS-1:0]   load_state;
  logic                     is_last;
  logic                     in_fire;
  logic                     out_fire;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COLS; gi++) begin : g_key_word
      assign key_word[gi] = key_q[32*gi +: 32];
    end
  endgenerate

  // Column 0 uses the live key; later columns use the copy latched at column 0.
  assign kw         = (col_cnt_q == '0) ? round_key[31:0] : key_word[col_cnt_q];
  assign keyed      = in_word ^ kw;
  assign load_state = {keyed, acc_q[32*(NUM_COLS-1)-1:0]};
  assign is_last    = (col_cnt_q == LAST_COL);
  assign in_ready   = !is_last || !out_valid_q || out_ready;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid_q && out_ready;

  always_comb begin
    col_cnt_d   = col_cnt_q;
    acc_d       = acc_q;
    key_d       = key_q;
    out_state_d = out_state_q;
    out_valid_d = out_valid_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (in_fire) begin
      if (col_cnt_q == '0) begin
        key_d = round_key;
      end
      if (is_last) begin
        // A same-cycle consume and reload keeps out_valid high with no bubble.
        out_state_d = load_state;
        out_valid_d = 1'b1;
        col_cnt_d   = '0;
        acc_d       = '0;
      end else begin
        for (int c = 0; c < NUM_COLS - 1; c++) begin
          if (col_cnt_q == CW'(c)) begin
            acc_d[32*c +: 32] = keyed;
          end
        end
        col_cnt_d = col_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt_q   <= '0;
      acc_q       <= '0;
      key_q       <= '0;
      out_state_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      col_cnt_q   <= col_cnt_d;
      acc_q       <= acc_d;
      key_q       <= key_d;
      out_state_q <= out_state_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_state = out_state_q;
  assign out_valid = out_valid_q;
  assign busy      = (col_cnt_q != '0);

`ifdef ARK_PARITY_EN
  logic [4*NUM_COLS-1:0] parity_q, parity_d;
  logic [4*NUM_COLS-1:0] load_parity;

  for (gi = 0; gi < 4*NUM_COLS; gi++) begin : g_parity
    assign load_parity[gi] = ^load_state[8*gi +: 8];
  end

  // Parity loads on exactly the same condition as out_state so the two stay paired.
  always_comb begin
    parity_d = parity_q;
    if (in_fire && is_last) begin
      parity_d = load_parity;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= '0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_add_round_key_collect.sv
// Directed bench for add_round_key_collect using FIPS-197 round-1 data and a
// hand-computed second block; inputs change and outputs are checked on the falling edge.
module tb_add_round_key_collect;

  localparam int NC = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_word;
  logic [32*NC-1:0] round_key;
  logic            out_valid;
  logic            out_ready;
  logic [32*NC-1:0] out_state;
  logic            busy;
`ifdef ARK_PARITY_EN
  logic [4*NC-1:0] out_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] fips_key   = {32'h05766c2a, 32'h3939a323, 32'hb12c5488, 32'h17fefaa0};
  logic [127:0] fips_state = {32'h49506a02, 32'h43ea5b6b, 32'h2b359f68, 32'hf27f9ca4};
  logic [31:0]  fips_w [4] = '{32'he5816604, 32'h9a19cbe0, 32'h7ad3f848, 32'h4c260628};
  logic [127:0] b_key      = {32'h88888888, 32'h44444444, 32'h22222222, 32'h11111111};
  logic [127:0] b_state    = {32'h2d2d2d2d, 32'h5670123c, 32'hdddddddd, 32'h11111111};
  logic [31:0]  b_w [4]    = '{32'h00000000, 32'hffffffff, 32'h12345678, 32'ha5a5a5a5};
  logic [15:0]  fips_par   = 16'h9f1d;

  always #5 clk = ~clk;

  add_round_key_collect #(.NUM_COLS(NC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
`ifdef ARK_PARITY_EN
    .out_parity(out_parity),
`endif
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [127:0] junk_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Entered on a falling edge; returns on the falling edge after the transfer.
  task automatic xfer(input logic [31:0] w, input logic [127:0] key);
    int waited = 0;
    in_valid  = 1'b1;
    in_word   = w;
    round_key = key;
    #1;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("xfer_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    round_key = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_out_state", out_state, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);

    // FIPS block A, key pulled to zero after column 0, idle gap mid-block.
    xfer(fips_w[0], fips_key);
    check("a_col0_busy", {127'd0, busy}, 128'd1);
    check("a_col0_valid", {127'd0, out_valid}, 128'd0);
    xfer(fips_w[1], 128'd0);
    repeat (3) @(negedge clk);
    check("a_hold_busy", {127'd0, busy}, 128'd1);
    xfer(fips_w[2], 128'd0);
    check("a_pre_final_valid", {127'd0, out_valid}, 128'd0);
    xfer(fips_w[3], 128'd0);
    check("a_out_valid", {127'd0, out_valid}, 128'd1);
    check("a_out_state", out_state, fips_state);
    check("a_busy_clear", {127'd0, busy}, 128'd0);
`ifdef ARK_PARITY_EN
    check("a_parity", {112'd0, out_parity}, {112'd0, fips_par});
`endif

    // Backpressure: block B collects while A is held.
    xfer(b_w[0], b_key);
    xfer(b_w[1], junk_key());
    xfer(b_w[2], junk_key());
    in_valid  = 1'b1;
    in_word   = b_w[3];
    round_key = junk_key();
    #1;
    check("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
    @(posedge clk);
    @(negedge clk);
    check("bp_state_held", out_state, fips_state);
    check("bp_valid_held", {127'd0, out_valid}, 128'd1);
    check("bp_busy", {127'd0, busy}, 128'd1);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_high", {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp_swap_valid", {127'd0, out_valid}, 128'd1);
    check("bp_swap_state", out_state, b_state);
    check("bp_swap_busy", {127'd0, busy}, 128'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_drain_valid", {127'd0, out_valid}, 128'd0);

    // Back-to-back, out_ready held high: A then B in eight consecutive words.
    for (int k = 0; k < 8; k++) begin
      in_valid  = 1'b1;
      in_word   = (k < 4) ? fips_w[k] : b_w[k-4];
      round_key = (k == 0) ? fips_key : (k == 4) ? b_key : junk_key();
      #1;
      check($sformatf("b2b_in_ready_%0d", k), {127'd0, in_ready}, 128'd1);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("b2b_out_valid_%0d", k), {127'd0, out_valid},
            (k == 3 || k == 7) ? 128'd1 : 128'd0);
      if (k == 3) check("b2b_state_a", out_state, fips_state);
      if (k == 7) check("b2b_state_b", out_state, b_state);
    end
    in_valid = 1'b0;

    // Reset after two words discards the partial block.
    out_ready = 1'b0;
    xfer(b_w[0], b_key);
    xfer(b_w[1], junk_key());
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", {127'd0, busy}, 128'd0);
    check("mid_rst_valid", {127'd0, out_valid}, 128'd0);
    check("mid_rst_state", out_state, 128'd0);
    check("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
    xfer(fips_w[0], fips_key);
    xfer(fips_w[1], junk_key());
    xfer(fips_w[2], junk_key());
    xfer(fips_w[3], junk_key());
    check("post_rst_valid", {127'd0, out_valid}, 128'd1);
    check("post_rst_state", out_state, fips_state);
`ifdef ARK_PARITY_EN
    check("post_rst_parity_b0", {127'd0, out_parity[0]}, 128'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
